// File: rtl/vend_token_ctrl.sv
// Vending token controller: pops coin/select/cancel tokens from the upstream
// 8-bit token FIFO and maintains credit, dispense pulses and change return.
module vend_token_ctrl #(
  parameter int unsigned PRICE0     = 50,
  parameter int unsigned PRICE1     = 75,
  parameter int unsigned PRICE2     = 100,
  parameter int unsigned PRICE3     = 150,
  parameter int unsigned CREDIT_MAX = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd,
  output logic [7:0] credit,
  output logic       vend,
  output logic [1:0] vend_id,
  output logic       change_5,
  output logic       coin_reject,
  output logic       sel_denied,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam logic [1:0] TOK_COIN   = 2'b00;
  localparam logic [1:0] TOK_SELECT = 2'b01;
  localparam logic [1:0] TOK_CANCEL = 2'b10;

  localparam logic [8:0] CREDIT_MAX_9 = 9'(CREDIT_MAX);

  state_t     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic       fifo_rd_q, fifo_rd_d;
  logic       vend_q, vend_d;
  logic [1:0] vend_id_q, vend_id_d;
  logic       change_5_q, change_5_d;
  logic       coin_reject_q, coin_reject_d;
  logic       sel_denied_q, sel_denied_d;
  logic       busy_q, busy_d;

  logic [8:0] coin_sum;
  logic [7:0] sel_price;
  logic [7:0] remainder;

  // Token payload bits [5:2] carry no meaning for this controller.
  logic unused_tok_bits;
  assign unused_tok_bits = ^fifo_dout[5:2];

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    case (code)
      2'b00:   coin_value = 8'd5;
      2'b01:   coin_value = 8'd10;
      2'b10:   coin_value = 8'd25;
      default: coin_value = 8'd100;
    endcase
  endfunction

  function automatic logic [7:0] price_of(input logic [1:0] id);
    case (id)
      2'd0:    price_of = 8'(PRICE0);
      2'd1:    price_of = 8'(PRICE1);
      2'd2:    price_of = 8'(PRICE2);
      default: price_of = 8'(PRICE3);
    endcase
  endfunction

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    fifo_rd_d     = 1'b0;
    vend_d        = 1'b0;
    vend_id_d     = 2'd0;
    change_5_d    = 1'b0;
    coin_reject_d = 1'b0;
    sel_denied_d  = 1'b0;
    coin_sum      = {1'b0, credit_q} + {1'b0, coin_value(fifo_dout[1:0])};
    sel_price     = price_of(fifo_dout[1:0]);
    remainder     = credit_q - sel_price;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d   = FETCH;
          fifo_rd_d = 1'b1;
        end
      end

      FETCH: state_d = DECODE;

      DECODE: begin
        state_d = IDLE;
        case (fifo_dout[7:6])
          TOK_COIN: begin
            if (coin_sum <= CREDIT_MAX_9) credit_d = coin_sum[7:0];
            else                          coin_reject_d = 1'b1;
          end
          TOK_SELECT: begin
            if (credit_q >= sel_price) begin
              credit_d  = remainder;
              vend_d    = 1'b1;
              vend_id_d = fifo_dout[1:0];
              // Change starts in the same cycle as the vend pulse.
              if (remainder != 8'd0) begin
                state_d    = CHANGE;
                change_5_d = 1'b1;
              end
            end else begin
              sel_denied_d = 1'b1;
            end
          end
          TOK_CANCEL: begin
            if (credit_q != 8'd0) begin
              state_d    = CHANGE;
              change_5_d = 1'b1;
            end
          end
          default: ;
        endcase
      end

      CHANGE: begin
        // Floor at zero so credit can never wrap, even if it were not a multiple of 5.
        if (credit_q <= 8'd5) begin
          credit_d = 8'd0;
          state_d  = IDLE;
        end else begin
          credit_d   = credit_q - 8'd5;
          change_5_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      credit_q      <= 8'd0;
      fifo_rd_q     <= 1'b0;
      vend_q        <= 1'b0;
      vend_id_q     <= 2'd0;
      change_5_q    <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_denied_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      fifo_rd_q     <= fifo_rd_d;
      vend_q        <= vend_d;
      vend_id_q     <= vend_id_d;
      change_5_q    <= change_5_d;
      coin_reject_q <= coin_reject_d;
      sel_denied_q  <= sel_denied_d;
      busy_q        <= busy_d;
    end
  end

  assign fifo_rd     = fifo_rd_q;
  assign credit      = credit_q;
  assign vend        = vend_q;
  assign vend_id     = vend_id_q;
  assign change_5    = change_5_q;
  assign coin_reject = coin_reject_q;
  assign sel_denied  = sel_denied_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vend_token_ctrl.sv
// Directed bench for vend_token_ctrl with a behavioural token FIFO.
module tb_vend_token_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd;
  logic [7:0] credit;
  logic       vend;
  logic [1:0] vend_id;
  logic       change_5;
  logic       coin_reject;
  logic       sel_denied;
  logic       busy;

  always #5 clk = ~clk;

  vend_token_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_dout   (fifo_dout),
    .fifo_rd     (fifo_rd),
    .credit      (credit),
    .vend        (vend),
    .vend_id     (vend_id),
    .change_5    (change_5),
    .coin_reject (coin_reject),
    .sel_denied  (sel_denied),
    .busy        (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [7:0] tokq[$];

  int         n_vend, n_c5, c5_run, c5_max, n_rej, n_den, n_rd;
  logic [1:0] last_vid;
  logic       vend_c5;
  logic [7:0] vend_credit;
  logic       prev_rd = 1'b0;
  logic       prev_busy = 1'b0;
  logic       prev_empty = 1'b1;

  task automatic clear_counts();
    n_vend = 0; n_c5 = 0; c5_run = 0; c5_max = 0;
    n_rej = 0; n_den = 0; n_rd = 0;
    last_vid = 2'd0; vend_c5 = 1'b0; vend_credit = 8'd0;
  endtask

  // Per-cycle monitor followed by the FIFO model, both on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("rd_back_to_back", {31'd0, fifo_rd & prev_rd}, 32'd0);
      if (!prev_busy && prev_empty) check("rd_from_idle_empty", {31'd0, fifo_rd}, 32'd0);
      if (vend) begin
        n_vend++;
        last_vid = vend_id;
        vend_c5 = change_5;
        vend_credit = credit;
      end
      if (change_5) begin
        n_c5++;
        c5_run++;
        if (c5_run > c5_max) c5_max = c5_run;
      end else begin
        c5_run = 0;
      end
      if (coin_reject) n_rej++;
      if (sel_denied)  n_den++;
      if (fifo_rd)     n_rd++;
    end
    if (fifo_rd && tokq.size() > 0) fifo_dout = tokq.pop_front();
    fifo_empty = (tokq.size() == 0);
    prev_rd    = fifo_rd;
    prev_busy  = busy;
    prev_empty = fifo_empty;
  end

  task automatic push(input logic [7:0] tok);
    @(posedge clk);
    #2;
    tokq.push_back(tok);
  endtask

  // Push one token and wait until it has been consumed and the FSM is idle.
  task automatic send(input logic [7:0] tok);
    int k;
    push(tok);
    k = 0;
    while (tokq.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (busy && k < 300);
    check("token_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fifo_rd"}, {31'd0, fifo_rd}, 32'd0);
    check({tag, "_vend"}, {31'd0, vend}, 32'd0);
    check({tag, "_vend_id"}, {30'd0, vend_id}, 32'd0);
    check({tag, "_change_5"}, {31'd0, change_5}, 32'd0);
    check({tag, "_coin_reject"}, {31'd0, coin_reject}, 32'd0);
    check({tag, "_sel_denied"}, {31'd0, sel_denied}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_credit"}, {24'd0, credit}, 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    fifo_dout = 8'd0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("por");
    @(negedge clk);
    rst = 1'b0;

    // Exact vend: three quarters then product 1 (75).
    clear_counts();
    send(8'h02); check("s1_credit25", {24'd0, credit}, 32'd25);
    send(8'h02); check("s1_credit50", {24'd0, credit}, 32'd50);
    send(8'h02); check("s1_credit75", {24'd0, credit}, 32'd75);
    send(8'h41);
    check("s1_vend_count", n_vend, 32'd1);
    check("s1_vend_id", {30'd0, last_vid}, 32'd1);
    check("s1_credit0", {24'd0, credit}, 32'd0);
    check("s1_no_change", n_c5, 32'd0);
    check("s1_busy", {31'd0, busy}, 32'd0);

    // Vend with change: dollar then product 0 (50) leaves 50 cents.
    clear_counts();
    send(8'h03); check("s2_credit100", {24'd0, credit}, 32'd100);
    send(8'h40);
    check("s2_vend_count", n_vend, 32'd1);
    check("s2_vend_id", {30'd0, last_vid}, 32'd0);
    check("s2_vend_credit", {24'd0, vend_credit}, 32'd50);
    check("s2_change_with_vend", {31'd0, vend_c5}, 32'd1);
    check("s2_change_cycles", n_c5, 32'd10);
    check("s2_change_run", c5_max, 32'd10);
    check("s2_credit0", {24'd0, credit}, 32'd0);

    // Credit ceiling: 200 accepted, a further nickel refused.
    clear_counts();
    send(8'h03);
    send(8'h03); check("s3_credit200", {24'd0, credit}, 32'd200);
    send(8'h00);
    check("s3_reject_count", n_rej, 32'd1);
    check("s3_credit_held", {24'd0, credit}, 32'd200);
    clear_counts();
    send(8'h80);
    check("s3_cancel_change", n_c5, 32'd40);
    check("s3_credit0", {24'd0, credit}, 32'd0);

    // Denial, cancel and reserved token.
    clear_counts();
    send(8'h02);
    send(8'h43);
    check("s4_denied_count", n_den, 32'd1);
    check("s4_no_vend", n_vend, 32'd0);
    check("s4_credit25", {24'd0, credit}, 32'd25);
    clear_counts();
    send(8'h80);
    check("s4_cancel_change", n_c5, 32'd5);
    check("s4_cancel_run", c5_max, 32'd5);
    check("s4_credit0", {24'd0, credit}, 32'd0);
    clear_counts();
    send(8'hC0);
    check("s4_reserved_quiet", n_vend + n_c5 + n_rej + n_den, 32'd0);
    check("s4_reserved_credit", {24'd0, credit}, 32'd0);

    // Reset asserted in the middle of change return.
    send(8'h03);
    push(8'h80);
    k = 0;
    while (!change_5 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("s5_change_started", {31'd0, change_5}, 32'd1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("s5_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
    repeat (20) @(posedge clk);
    #1;
    check("s5_no_reads", n_rd, 32'd0);
    check("s5_idle", {31'd0, busy}, 32'd0);
    check("s5_credit0", {24'd0, credit}, 32'd0);
    send(8'h01);
    check("s5_resume_credit", {24'd0, credit}, 32'd10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
